sdata_wipe_ctrl: RTL
====================

// Module: sdata_wipe_ctrl
// PURPOSE
//  Responder to the access-control monitor's kill/reset request.
//  On a kill request it holds the core in reset and zeroizes the secure data
//  region (SDATA) through a word-write port to data memory. It releases the
//  core only after the wipe completes and the monitor has dropped its request.
//  It sits between the monitor's reset output and the core's reset and memory-write mux.
// PARAMETERS
//  SDATA_BASE  16'h0400  first byte address of the secure data region; must be even
//  SDATA_SIZE  16'h0C00  region size in bytes; must be even and >= 2
//  MIN_HOLD    4         cycles spent in HOLD before the wipe starts; 0 is legal
//  WIPE_DATA   16'h0000  value written to every word
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous, active-low reset (power-on only)
//  kill_req   in   1   level request from the access monitor; 1 = violation active
//  cpu_hold   out  1   holds the core in reset; 1 = held
//  mem_req    out  1   write request to data memory
//  mem_gnt    in   1   grant; a write is accepted on any cycle with mem_req && mem_gnt
//  mem_addr   out  16  byte address of the current write; always even
//  mem_wdata  out  16  write data
//  busy       out  1   1 in any state other than IDLE
//  wipe_done  out  1   one-cycle pulse on return to IDLE
//  kill_cnt   out  8   count of kill events (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE. cpu_hold=0, mem_req=0, mem_addr=SDATA_BASE, mem_wdata=0,
//    busy=0, wipe_done=0, kill_cnt=0. All outputs are registered.
//  - Reset asserted mid-operation aborts the sequence immediately. After reset,
//    the block is in IDLE and the wipe is not resumed.
//  - States and transitions:
//    IDLE:  if kill_req=1 at a posedge, go to HOLD. cpu_hold=1 and busy=1 from the next cycle.
//    HOLD:  count MIN_HOLD cycles, then go to WIPE. With MIN_HOLD=0, go to WIPE on the
//           cycle after entering HOLD.
//    WIPE:  mem_req=1, mem_addr starts at SDATA_BASE, mem_wdata=WIPE_DATA.
//           addr and data stay stable while mem_req && !mem_gnt.
//           Each grant advances mem_addr by 2 on the next cycle.
//           The grant on SDATA_BASE+SDATA_SIZE-2 is the last write: mem_req drops on the
//           next cycle and the state goes to DRAIN.
//           Total writes = SDATA_SIZE/2. There is no wrap and no write beyond the region end.
//    DRAIN: mem_req=0. Stay until kill_req=0 at a posedge, then go to IDLE.
//           On that transition: cpu_hold=0, busy=0, wipe_done=1 for one cycle,
//           mem_addr returns to SDATA_BASE.
//  - kill_req is ignored in HOLD and WIPE; falling or re-rising there has no effect.
//  - kill_req=1 throughout DRAIN keeps the block in DRAIN indefinitely.
//  - kill_req=1 in the same cycle as the wipe_done pulse (IDLE): go to HOLD next cycle,
//    which starts a new wipe.
//  - cpu_hold is 1 in every state except IDLE.
//  - mem_gnt is ignored when mem_req=0.
// CONFIGURATION
//  KILL_CNT_EN defined: kill_cnt increments by 1 on each IDLE->HOLD transition and
//    saturates at 8'hFF. It clears only on reset_n.
//  KILL_CNT_EN undefined: kill_cnt is tied to 8'h00 and no counter logic is built.
// TESTING (SDATA_SIZE=16'h0008, MIN_HOLD=2 unless noted)
//  1. Release reset_n with kill_req=0 -> all outputs at reset values; cpu_hold=0 for 20 cycles.
//  2. Pulse kill_req for 1 cycle, mem_gnt=1 always -> cpu_hold rises next cycle;
//     writes of 0 to 0x400/402/404/406 on consecutive cycles; the block waits in DRAIN;
//     drop kill_req -> wipe_done pulses once, cpu_hold=0.
//  3. mem_gnt low for 3 cycles on 0x402 -> mem_addr holds 0x402 with mem_req=1;
//     exactly 4 writes total, no duplicates.
//  4. kill_req held high 10 cycles past the last write -> block stays in DRAIN,
//     cpu_hold=1, no extra writes; release on kill_req=0.
//  5. reset_n low during WIPE at 0x404 -> all outputs reset asynchronously;
//     IDLE after release; no further writes.
//  6. KILL_CNT_EN defined, 3 complete kill events -> kill_cnt=3;
//     undefined -> kill_cnt=0. MIN_HOLD=0 -> first write on the 2nd cycle after kill_req.

Source files
------------

// File: rtl/sdata_wipe_ctrl.sv
// Kill-request responder: holds the core in reset, zeroizes the SDATA region, then releases the core.
// Optional build macro KILL_CNT_EN adds a saturating kill-event counter on kill_cnt.
module sdata_wipe_ctrl #(
  parameter logic [15:0] SDATA_BASE = 16'h0400,
  parameter logic [15:0] SDATA_SIZE = 16'h0C00,
  parameter int unsigned MIN_HOLD   = 4,
  parameter logic [15:0] WIPE_DATA  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        kill_req,
  output logic        cpu_hold,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        wipe_done,
  output logic [7:0]  kill_cnt
);

  localparam logic [15:0] LAST_ADDR = SDATA_BASE + SDATA_SIZE - 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WIPE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_hold_cnt;
  logic [15:0] w_hold_cnt_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] w_mem_addr_nxt;
  logic [15:0] r_mem_wdata;
  logic [15:0] w_mem_wdata_nxt;
  logic        r_mem_req;
  logic        w_mem_req_nxt;
  logic        r_cpu_hold;
  logic        r_busy;
  logic        r_wipe_done;
  logic        w_wipe_done_nxt;
  logic        w_accept;
  logic        w_hold_last;

  assign w_accept    = r_mem_req & mem_gnt;
  // HOLD always lasts at least one cycle, so MIN_HOLD of 0 and 1 behave alike.
  assign w_hold_last = ({16'h0000, r_hold_cnt} + 32'd1) >= MIN_HOLD;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_req_nxt   = r_mem_req;
    w_wipe_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hold_cnt_nxt  = 16'd0;
        w_mem_addr_nxt  = SDATA_BASE;
        w_mem_wdata_nxt = 16'h0000;
        w_mem_req_nxt   = 1'b0;
        if (kill_req) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (w_hold_last) begin
          w_state_nxt     = ST_WIPE;
          w_mem_req_nxt   = 1'b1;
          w_mem_addr_nxt  = SDATA_BASE;
          w_mem_wdata_nxt = WIPE_DATA;
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + 16'd1;
        end
      end
      ST_WIPE: begin
        if (w_accept) begin
          if (r_mem_addr == LAST_ADDR) begin
            w_state_nxt     = ST_DRAIN;
            w_mem_req_nxt   = 1'b0;
            w_mem_wdata_nxt = 16'h0000;
          end else begin
            w_mem_addr_nxt  = r_mem_addr + 16'd2;
          end
        end else begin
          w_state_nxt = ST_WIPE;
        end
      end
      ST_DRAIN: begin
        if (!kill_req) begin
          w_state_nxt     = ST_IDLE;
          w_mem_addr_nxt  = SDATA_BASE;
          w_wipe_done_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_mem_req_nxt   = 1'b0;
        w_mem_addr_nxt  = SDATA_BASE;
        w_mem_wdata_nxt = 16'h0000;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt  <= 16'd0;
      r_mem_addr  <= SDATA_BASE;
      r_mem_wdata <= 16'h0000;
      r_mem_req   <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_busy      <= 1'b0;
      r_wipe_done <= 1'b0;
    end else begin
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_cpu_hold  <= (w_state_nxt != ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_wipe_done <= w_wipe_done_nxt;
    end
  end

`ifdef KILL_CNT_EN
  logic [7:0] r_kill_cnt;

  // Saturating count of IDLE->HOLD transitions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kill_cnt <= 8'h00;
    end else if ((r_state == ST_IDLE) && kill_req && (r_kill_cnt != 8'hFF)) begin
      r_kill_cnt <= r_kill_cnt + 8'd1;
    end else begin
      r_kill_cnt <= r_kill_cnt;
    end
  end

  assign kill_cnt = r_kill_cnt;
`else
  assign kill_cnt = 8'h00;
`endif

  assign cpu_hold  = r_cpu_hold;
  assign busy      = r_busy;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wipe_done = r_wipe_done;

endmodule
